// File: rtl/aes_round_stage.sv
// rtl/aes_round_stage.sv - one AES round per packet with key-slot bank, 2-entry skid buffer and counters

package aes_round_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    // Byte i of the state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3
    function automatic logic [127:0] enc_round(input logic [127:0] st, input logic [127:0] k);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = sbox(a[4*((c+r)%4)+r]);
        for (int c = 0; c < 4; c++) begin
            res[127-8*(4*c+0) -: 8] = xtime(b[4*c]) ^ xtime(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
            res[127-8*(4*c+1) -: 8] = b[4*c] ^ xtime(b[4*c+1]) ^ xtime(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
            res[127-8*(4*c+2) -: 8] = b[4*c] ^ b[4*c+1] ^ xtime(b[4*c+2]) ^ xtime(b[4*c+3]) ^ b[4*c+3];
            res[127-8*(4*c+3) -: 8] = xtime(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xtime(b[4*c+3]);
        end
        return res ^ k;
    endfunction

    // Equivalent-inverse-cipher round: the inverse bank holds InvMixColumns-transformed round keys
    function automatic logic [127:0] dec_round(input logic [127:0] st, input logic [127:0] k);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = inv_sbox(a[4*((c+4-r)%4)+r]);
        for (int c = 0; c < 4; c++) begin
            res[127-8*(4*c+0) -: 8] = gf_mul(8'h0e, b[4*c]) ^ gf_mul(8'h0b, b[4*c+1]) ^ gf_mul(8'h0d, b[4*c+2]) ^ gf_mul(8'h09, b[4*c+3]);
            res[127-8*(4*c+1) -: 8] = gf_mul(8'h09, b[4*c]) ^ gf_mul(8'h0e, b[4*c+1]) ^ gf_mul(8'h0b, b[4*c+2]) ^ gf_mul(8'h0d, b[4*c+3]);
            res[127-8*(4*c+2) -: 8] = gf_mul(8'h0d, b[4*c]) ^ gf_mul(8'h09, b[4*c+1]) ^ gf_mul(8'h0e, b[4*c+2]) ^ gf_mul(8'h0b, b[4*c+3]);
            res[127-8*(4*c+3) -: 8] = gf_mul(8'h0b, b[4*c]) ^ gf_mul(8'h0d, b[4*c+1]) ^ gf_mul(8'h09, b[4*c+2]) ^ gf_mul(8'h0e, b[4*c+3]);
        end
        return res ^ k;
    endfunction

endpackage

module aes_enc_round (
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] result
);
    assign result = aes_round_pkg::enc_round(state, key);
endmodule

module aes_dec_round (
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] result
);
    assign result = aes_round_pkg::dec_round(state, key);
endmodule

module aes_round_stage #(
    parameter  int NUM_SLOTS = 4,
    parameter  int TAG_W     = 4,
    parameter  int CNT_W     = 16,
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    input  logic              in_de,
    input  logic [SLOT_W-1:0] in_slot,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              in_bypass,
    input  logic              key_wr_en,
    input  logic              key_wr_inv,
    input  logic [SLOT_W-1:0] key_wr_slot,
    input  logic [127:0]      key_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic              out_de,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic [CNT_W-1:0]  cnt_enc,
    output logic [CNT_W-1:0]  cnt_dec
);
    localparam logic [SLOT_W:0] NUM_SLOTS_W = (SLOT_W+1)'(NUM_SLOTS);

    logic [127:0] key_q [NUM_SLOTS];
    logic [127:0] key_d [NUM_SLOTS];
    logic [127:0] inv_key_q [NUM_SLOTS];
    logic [127:0] inv_key_d [NUM_SLOTS];

    logic              r0_valid_q, r0_valid_d, r1_valid_q, r1_valid_d;
    logic [127:0]      r0_data_q, r0_data_d, r1_data_q, r1_data_d;
    logic              r0_de_q, r0_de_d, r1_de_q, r1_de_d;
    logic [TAG_W-1:0]  r0_tag_q, r0_tag_d, r1_tag_q, r1_tag_d;
    logic              r0_err_q, r0_err_d, r1_err_q, r1_err_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  cnt_enc_q, cnt_enc_d, cnt_dec_q, cnt_dec_d;

    logic [127:0] enc_key, dec_key, enc_in, dec_in, enc_out, dec_out, new_data;
    logic         slot_ok, use_core, new_err, accept, drain, deliver;

    // Key bank update; writes to slots outside the bank match no entry and vanish
    always_comb begin
        key_d     = key_q;
        inv_key_d = inv_key_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (key_wr_en && key_wr_slot == SLOT_W'(i)) begin
                if (key_wr_inv) inv_key_d[i] = key_wr_data;
                else            key_d[i]     = key_wr_data;
            end
        end
    end

    // Key lookup for the incoming packet (reads the pre-write bank contents)
    always_comb begin
        enc_key = '0;
        dec_key = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (in_slot == SLOT_W'(i)) begin
                enc_key = key_q[i];
                dec_key = inv_key_q[i];
            end
        end
    end

    assign slot_ok  = {1'b0, in_slot} < NUM_SLOTS_W;
    assign use_core = slot_ok & ~in_bypass;
    assign enc_in   = (use_core & ~in_de) ? in_data : '0;
    assign dec_in   = (use_core &  in_de) ? in_data : '0;

    aes_enc_round u_enc (.state(enc_in), .key(enc_key), .result(enc_out));
    aes_dec_round u_dec (.state(dec_in), .key(dec_key), .result(dec_out));

    // Packet payload: bypass ignores the slot entirely, a bad slot yields zero data and an error flag
    always_comb begin
        new_err  = 1'b0;
        new_data = '0;
        if (in_bypass)    new_data = in_data;
        else if (!slot_ok) new_err = 1'b1;
        else if (in_de)   new_data = dec_out;
        else              new_data = enc_out;
    end

    assign accept  = in_valid & in_ready_q & ~flush;
    assign drain   = r0_valid_q & out_ready;
    assign deliver = drain & ~flush & ~r0_err_q;

    // Skid buffer: R0 drives the output, R1 absorbs the packet accepted while R0 is stalled
    always_comb begin
        r0_valid_d = r0_valid_q; r0_data_d = r0_data_q; r0_de_d = r0_de_q; r0_tag_d = r0_tag_q; r0_err_d = r0_err_q;
        r1_valid_d = r1_valid_q; r1_data_d = r1_data_q; r1_de_d = r1_de_q; r1_tag_d = r1_tag_q; r1_err_d = r1_err_q;
        if (flush) begin
            r0_valid_d = 1'b0;
            r1_valid_d = 1'b0;
        end else begin
            if (drain) begin
                if (r1_valid_q) begin
                    r0_data_d  = r1_data_q; r0_de_d = r1_de_q; r0_tag_d = r1_tag_q; r0_err_d = r1_err_q;
                    r1_valid_d = 1'b0;
                end else begin
                    r0_valid_d = 1'b0;
                end
            end
            if (accept) begin
                if (!r0_valid_q || (drain && !r1_valid_q)) begin
                    r0_valid_d = 1'b1; r0_data_d = new_data; r0_de_d = in_de; r0_tag_d = in_tag; r0_err_d = new_err;
                end else begin
                    r1_valid_d = 1'b1; r1_data_d = new_data; r1_de_d = in_de; r1_tag_d = in_tag; r1_err_d = new_err;
                end
            end
        end
        in_ready_d = ~r1_valid_d;
    end

    // Saturating delivery counters per direction
    always_comb begin
        cnt_enc_d = cnt_enc_q;
        cnt_dec_d = cnt_dec_q;
        if (deliver) begin
            if (r0_de_q) begin
                if (cnt_dec_q != '1) cnt_dec_d = cnt_dec_q + 1'b1;
            end else begin
                if (cnt_enc_q != '1) cnt_enc_d = cnt_enc_q + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                key_q[i]     <= '0;
                inv_key_q[i] <= '0;
            end
            r0_valid_q <= 1'b0; r0_data_q <= '0; r0_de_q <= 1'b0; r0_tag_q <= '0; r0_err_q <= 1'b0;
            r1_valid_q <= 1'b0; r1_data_q <= '0; r1_de_q <= 1'b0; r1_tag_q <= '0; r1_err_q <= 1'b0;
            in_ready_q <= 1'b0;
            cnt_enc_q  <= '0;
            cnt_dec_q  <= '0;
        end else begin
            key_q      <= key_d;
            inv_key_q  <= inv_key_d;
            r0_valid_q <= r0_valid_d; r0_data_q <= r0_data_d; r0_de_q <= r0_de_d; r0_tag_q <= r0_tag_d; r0_err_q <= r0_err_d;
            r1_valid_q <= r1_valid_d; r1_data_q <= r1_data_d; r1_de_q <= r1_de_d; r1_tag_q <= r1_tag_d; r1_err_q <= r1_err_d;
            in_ready_q <= in_ready_d;
            cnt_enc_q  <= cnt_enc_d;
            cnt_dec_q  <= cnt_dec_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = r0_valid_q;
    assign out_data  = r0_data_q;
    assign out_de    = r0_de_q;
    assign out_tag   = r0_tag_q;
    assign out_err   = r0_err_q;
    assign cnt_enc   = cnt_enc_q;
    assign cnt_dec   = cnt_dec_q;

endmodule

// File: tb/tb_aes_round_stage.sv
// tb/tb_aes_round_stage.sv - self-checking bench for aes_round_stage against a byte-matrix AES model

module tb_aes_round_stage;
    localparam int NS = 3;
    localparam int TW = 4;
    localparam int CW = 16;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rstn, flush, in_valid, in_de, in_bypass, key_wr_en, key_wr_inv, out_ready;
    logic [127:0]   in_data, key_wr_data;
    logic [SW-1:0]  in_slot, key_wr_slot;
    logic [TW-1:0]  in_tag;

    logic           in_ready, out_valid, out_de, out_err;
    logic [127:0]   out_data;
    logic [TW-1:0]  out_tag;
    logic [CW-1:0]  cnt_enc, cnt_dec;

    logic           s_in_ready, s_out_valid, s_out_de, s_out_err;
    logic [127:0]   s_out_data;
    logic [TW-1:0]  s_out_tag;
    logic [1:0]     s_cnt_enc, s_cnt_dec;

    aes_round_stage #(.NUM_SLOTS(NS), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_de(in_de), .in_slot(in_slot), .in_tag(in_tag), .in_bypass(in_bypass),
        .key_wr_en(key_wr_en), .key_wr_inv(key_wr_inv), .key_wr_slot(key_wr_slot), .key_wr_data(key_wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_de(out_de),
        .out_tag(out_tag), .out_err(out_err), .cnt_enc(cnt_enc), .cnt_dec(cnt_dec));

    aes_round_stage #(.NUM_SLOTS(4), .TAG_W(TW), .CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_de(in_de), .in_slot(in_slot), .in_tag(in_tag), .in_bypass(in_bypass),
        .key_wr_en(key_wr_en), .key_wr_inv(key_wr_inv), .key_wr_slot(key_wr_slot), .key_wr_data(key_wr_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_de(s_out_de),
        .out_tag(s_out_tag), .out_err(s_out_err), .cnt_enc(s_cnt_enc), .cnt_dec(s_cnt_dec));

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0]  d;
        logic          de;
        logic [TW-1:0] tag;
        logic          err;
    } pkt_t;

    pkt_t         m_q[$];
    logic [127:0] m_ek [NS];
    logic [127:0] m_dk [NS];
    int           m_cnt_enc, m_cnt_dec;
    logic         m_rdy;
    int           checks = 0;
    int           errors = 0;

    logic [7:0]   sb [256];
    logic [7:0]   isb [256];
    logic [7:0]   mc [4][4];
    logic [7:0]   imc [4][4];

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, acc;
        logic       hi;
        x = a; y = b; acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) acc = acc ^ x;
            hi = x[7];
            x  = x << 1;
            if (hi) x = x ^ 8'h1b;
            y = y >> 1;
        end
        return acc;
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s, cst;
        logic [7:0] base_f [4];
        logic [7:0] base_i [4];
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sb[x]  = s;
            isb[s] = 8'(x);
        end
        base_f[0] = 8'h02; base_f[1] = 8'h03; base_f[2] = 8'h01; base_f[3] = 8'h01;
        base_i[0] = 8'h0e; base_i[1] = 8'h0b; base_i[2] = 8'h0d; base_i[3] = 8'h09;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++) begin
                mc[r][j]  = base_f[(j - r + 4) % 4];
                imc[r][j] = base_i[(j - r + 4) % 4];
            end
    endtask

    // One round on a 4x4 state matrix: (Inv)SubBytes, (Inv)ShiftRows, (Inv)MixColumns, AddRoundKey
    function automatic logic [127:0] m_round(input logic [127:0] st, input logic [127:0] k, input logic dec);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   acc;
        logic [127:0] res;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = st[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = dec ? isb[s[r][(c+4-r)%4]] : sb[s[r][(c+r)%4]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ mul(dec ? imc[r][j] : mc[r][j], t[j][c]);
                res[127-8*(4*c+r) -: 8] = acc ^ k[127-8*(4*c+r) -: 8];
            end
        return res;
    endfunction

    function automatic pkt_t m_expect(input logic [127:0] d, input logic de, input int slot,
                                      input logic [TW-1:0] tag, input logic byp);
        pkt_t p;
        p.de = de; p.tag = tag; p.err = 1'b0; p.d = '0;
        if (byp)              p.d   = d;
        else if (slot >= NS)  p.err = 1'b1;
        else if (de)          p.d   = m_round(d, m_dk[slot], 1'b1);
        else                  p.d   = m_round(d, m_ek[slot], 1'b0);
        return p;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        for (int i = 0; i < NS; i++) begin m_ek[i] = '0; m_dk[i] = '0; end
        m_cnt_enc = 0; m_cnt_dec = 0; m_rdy = 1'b0;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_data = '0; in_de = 0; in_slot = '0; in_tag = '0; in_bypass = 0;
        key_wr_en = 0; key_wr_inv = 0; key_wr_slot = '0; key_wr_data = '0;
    endtask

    task automatic set_pkt(input logic [127:0] d, input logic de, input int slot, input int tag, input logic byp);
        in_valid = 1; in_data = d; in_de = de; in_slot = SW'(slot); in_tag = TW'(tag); in_bypass = byp;
    endtask

    // Compare current outputs with the model, then advance model and DUT across one rising edge
    task automatic cycle();
        pkt_t p;
        logic acc, drn;
        check("in_ready", in_ready, m_rdy);
        check("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("out_data", out_data, m_q[0].d);
            check("out_de", out_de, m_q[0].de);
            check("out_tag", out_tag, m_q[0].tag);
            check("out_err", out_err, m_q[0].err);
        end
        check("cnt_enc", cnt_enc, CW'(m_cnt_enc));
        check("cnt_dec", cnt_dec, CW'(m_cnt_dec));
        acc = in_valid && m_rdy && !flush;
        drn = (m_q.size() != 0) && out_ready;
        if (flush) begin
            m_q.delete();
        end else begin
            if (drn) begin
                p = m_q.pop_front();
                if (!p.err) begin
                    if (p.de) m_cnt_dec = (m_cnt_dec < 65535) ? m_cnt_dec + 1 : m_cnt_dec;
                    else      m_cnt_enc = (m_cnt_enc < 65535) ? m_cnt_enc + 1 : m_cnt_enc;
                end
            end
            if (acc) m_q.push_back(m_expect(in_data, in_de, int'(in_slot), in_tag, in_bypass));
        end
        if (key_wr_en && int'(key_wr_slot) < NS) begin
            if (key_wr_inv) m_dk[key_wr_slot] = key_wr_data;
            else            m_ek[key_wr_slot] = key_wr_data;
        end
        m_rdy = m_q.size() < 2;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] FIPS_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;

    initial begin
        logic [127:0] k, st, hold, kold, a_d, b_d;
        int           base_enc, base_dec;

        build_tables();
        idle_inputs();
        out_ready = 0;
        rstn      = 0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_data", out_data, 128'h0);
        check("rst out_tag", out_tag, 4'h0);
        check("rst out_err", out_err, 1'b0);
        check("rst out_de", out_de, 1'b0);
        check("rst in_ready", in_ready, 1'b0);
        check("rst cnt_enc", cnt_enc, 16'h0);
        rstn = 1;

        // FIPS-197 round 1 encrypt through slot 2
        key_wr_en = 1; key_wr_inv = 0; key_wr_slot = 2'd2; key_wr_data = FIPS_KEY;
        cycle();
        key_wr_en = 0; out_ready = 1;
        set_pkt(FIPS_IN, 0, 2, 5, 0);
        cycle();
        in_valid = 0;
        check("fips out_valid", out_valid, 1'b1);
        check("fips out_data", out_data, FIPS_OUT);
        check("fips out_tag", out_tag, 4'h5);
        cycle();
        check("fips cnt_enc", cnt_enc, 16'h1);

        // Decrypt through the inverse bank
        k = rnd128(); st = rnd128();
        key_wr_en = 1; key_wr_inv = 1; key_wr_slot = 2'd1; key_wr_data = k;
        cycle();
        key_wr_en = 0;
        set_pkt(st, 1, 1, 7, 0);
        cycle();
        in_valid = 0;
        check("dec out_data", out_data, m_round(st, k, 1'b1));
        check("dec out_de", out_de, 1'b1);
        cycle();
        check("dec cnt_dec", cnt_dec, 16'h1);

        // Back-pressure with three packets
        base_enc = m_cnt_enc;
        out_ready = 0;
        set_pkt(rnd128(), 0, 0, 1, 0); cycle();
        set_pkt(rnd128(), 0, 0, 2, 0); cycle();
        set_pkt(rnd128(), 0, 0, 3, 0);
        check("bp in_ready low", in_ready, 1'b0);
        hold = out_data;
        cycle();
        check("bp out stable", out_data, hold);
        out_ready = 1;
        cycle();
        cycle();
        in_valid = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("bp delivered 3", cnt_enc, CW'(base_enc + 3));

        // Key write in the same cycle as an accept
        kold = m_ek[0]; k = rnd128(); a_d = rnd128(); b_d = rnd128();
        key_wr_en = 1; key_wr_inv = 0; key_wr_slot = 2'd0; key_wr_data = k;
        set_pkt(a_d, 0, 0, 4, 0);
        cycle();
        key_wr_en = 0;
        set_pkt(b_d, 0, 0, 6, 0);
        check("race A old key", out_data, m_round(a_d, kold, 1'b0));
        cycle();
        in_valid = 0;
        check("race B new key", out_data, m_round(b_d, k, 1'b0));
        cycle();

        // Out-of-range slot and bypass
        base_enc = m_cnt_enc; base_dec = m_cnt_dec;
        set_pkt(rnd128(), 0, 3, 9, 0);
        cycle();
        in_valid = 0;
        check("err out_err", out_err, 1'b1);
        check("err out_data", out_data, 128'h0);
        check("err out_tag", out_tag, 4'h9);
        cycle();
        check("err cnt_enc", cnt_enc, CW'(base_enc));
        check("err cnt_dec", cnt_dec, CW'(base_dec));
        set_pkt(128'h0123456789abcdeffedcba9876543210, 1, 1, 2, 1);
        cycle();
        in_valid = 0;
        check("bypass data", out_data, 128'h0123456789abcdeffedcba9876543210);
        cycle();

        // Flush with both registers full
        out_ready = 0;
        set_pkt(rnd128(), 0, 1, 1, 0); cycle();
        set_pkt(rnd128(), 1, 0, 2, 0); cycle();
        set_pkt(rnd128(), 0, 2, 3, 0);
        flush = 1;
        cycle();
        flush = 0; in_valid = 0;
        check("flush out_valid", out_valid, 1'b0);
        check("flush in_ready", in_ready, 1'b1);
        out_ready = 1;
        set_pkt(FIPS_IN, 0, 2, 3, 0);
        cycle();
        in_valid = 0;
        check("flush key kept", out_data, FIPS_OUT);
        cycle();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            flush       = ($urandom_range(0, 29) == 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            in_data     = rnd128();
            in_de       = 1'($urandom);
            in_slot     = SW'($urandom_range(0, 3));
            in_tag      = TW'($urandom);
            in_bypass   = ($urandom_range(0, 7) == 0);
            out_ready   = ($urandom_range(0, 9) < 7);
            key_wr_en   = ($urandom_range(0, 9) == 0);
            key_wr_inv  = 1'($urandom);
            key_wr_slot = SW'($urandom_range(0, 3));
            key_wr_data = rnd128();
            cycle();
        end

        // Reset in the middle of traffic
        idle_inputs();
        out_ready = 0;
        set_pkt(rnd128(), 0, 0, 1, 0); cycle();
        set_pkt(rnd128(), 0, 0, 2, 0); cycle();
        in_valid = 0;
        #1;
        rstn = 0;
        #1;
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst out_data", out_data, 128'h0);
        check("midrst out_tag", out_tag, 4'h0);
        check("midrst in_ready", in_ready, 1'b0);
        check("midrst cnt_enc", cnt_enc, 16'h0);
        check("midrst cnt_dec", cnt_dec, 16'h0);
        @(negedge clk);
        rstn = 1;
        m_reset();
        cycle();

        // Saturation on the narrow-counter instance
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            set_pkt(rnd128(), 0, 0, i, 0);
            cycle();
        end
        in_valid = 0;
        cycle();
        cycle();
        check("sat wide cnt_enc", cnt_enc, 16'd5);
        check("sat cnt_enc", s_cnt_enc, 2'd3);
        check("sat cnt_dec", s_cnt_dec, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_round_stage.md
Name: aes_round_stage

Overview:
- Parametrised, back-pressurable successor to the single-key AES round register stage; performs one full AES round (encrypt or decrypt) per accepted packet.
- Key material is held in a bank of NUM_SLOTS encrypt/decrypt key pairs selected per packet.
- Adds valid/ready handshake with a 2-entry skid buffer, per-packet tag and bypass, slot-range error reporting, synchronous flush and saturating per-direction packet counters.
- Chained N-deep between the key schedule and the cipher controller inside the accelerator datapath.

Parameters:
NUM_SLOTS, 4, number of key slots; each slot holds one encrypt key and one inverse key; 1..16.
TAG_W, 4, width of the opaque per-packet tag carried alongside data; >=1.
CNT_W, 16, width of each saturating packet counter.
(derived, local) SLOT_W = max(1, clog2(NUM_SLOTS)).

Ports:
clk  in  1  clock.
rstn  in  1  asynchronous active-low reset.
flush  in  1  synchronous drop of all buffered packets.
in_valid  in  1  input packet valid.
in_ready  out  1  stage can accept a packet.
in_data  in  128  round input state.
in_de  in  1  0 = encrypt, 1 = decrypt.
in_slot  in  SLOT_W  key slot select.
in_tag  in  TAG_W  opaque tag.
in_bypass  in  1  1 = pass in_data unmodified.
key_wr_en  in  1  key bank write strobe.
key_wr_inv  in  1  0 = write encrypt key bank, 1 = write inverse key bank.
key_wr_slot  in  SLOT_W  slot to write.
key_wr_data  in  128  key value.
out_valid  out  1  output packet valid.
out_ready  in  1  downstream accepts.
out_data  out  128  round result.
out_de  out  1  direction of output packet.
out_tag  out  TAG_W  tag of output packet.
out_err  out  1  packet had an out-of-range slot.
cnt_enc  out  CNT_W  encrypt packets delivered (saturating).
cnt_dec  out  CNT_W  decrypt packets delivered (saturating).

Behaviour:
- Reset (rstn low, asynchronous):
  - Key banks, output register, skid register and counters all cleared to 0.
  - out_valid = 0, out_data = 0, out_de = 0, out_tag = 0, out_err = 0.
  - in_ready = 1 from the first clock edge after reset release.
  - Reset mid-operation discards in-flight packets and keys.
- Accept: a packet is accepted on a rising edge with in_valid & in_ready.
- Datapath:
  - Encrypt: out = encryptRound(in_data, key[in_slot]).
  - Decrypt: out = decryptRound(in_data, inv_key[in_slot]).
  - Existing round cores are instantiated unmodified, one of each; the core input is gated to 0 when its direction is not selected.
  - in_bypass = 1: out_data = in_data, no key use, counted in the counters by direction.
- Slot error: in_slot >= NUM_SLOTS gives out_data = 0, out_err = 1, packet still delivered with its tag; not counted.
- Latency: exactly 1 cycle from accept to out_valid when the output is not stalled.
- Buffering (2-entry skid):
  - out register (R0) and skid register (R1).
  - in_ready = ~R1.valid, taken from a register with no combinational path from out_ready.
  - On accept: if R0 is empty, or R0 drains this cycle (out_ready high) with R1 empty, load R0; otherwise load R1.
  - When R0 drains and R1 is full, R1 moves to R0 and R1 clears.
  - The output payload is stable while out_valid & ~out_ready.
  - Order is strictly preserved.
- Key bank writes:
  - A write takes effect at the clock edge.
  - A packet accepted in the same cycle as a write to its slot uses the OLD key; a packet accepted the next cycle uses the new key.
  - Packets already buffered are unaffected.
  - A write with key_wr_slot >= NUM_SLOTS is ignored.
- Flush:
  - Clears R0/R1 valid (both dropped, no counting) and suppresses any accept that cycle.
  - Key banks and counters are retained.
  - in_ready = 1 on the next cycle.
- Counters:
  - Increment on each delivered (out_valid & out_ready) non-error packet, selected by out_de.
  - Saturate at 2^CNT_W-1; they never wrap.
- Simultaneous accept and drain with both registers full cannot occur, because in_ready = 0.
- Throughput: 1 packet/cycle sustained when out_ready is held high.

Test Plan:
- FIPS-197 App. B encrypt: write slot 2 encrypt key a0fafe1788542cb123a339392a6c7605, send encrypt state 193de3bea0f4e22b9ac68d2ae9f84808 with slot 2, tag 5 -> next cycle out_valid = 1, out_data = a49c7ff2689f352b6b5bea43026a5049, out_tag = 5, cnt_enc = 1.
- Decrypt match: write the inverse bank with an arbitrary key, send a decrypt packet -> out_data equals the standalone decryptRound model output for the same state/key, out_de = 1, cnt_dec = 1.
- Back-pressure: hold out_ready = 0 and stream 3 packets -> first two accepted, in_ready = 0 on the 3rd, output stable; release out_ready -> all 3 emerge in order, with no loss and no duplication.
- Key write race: write a new slot 0 key in the same cycle as accepting packet A (slot 0), then accept B -> A uses the old key and B uses the new key.
- Errors/bypass: with NUM_SLOTS = 3, send slot 3 -> out_err = 1, out_data = 0, counters unchanged; send a bypass packet with data 0x0123... -> output is identical.
- Flush/saturation/reset: flush with 2 packets buffered -> out_valid = 0 next cycle and keys still valid; with CNT_W = 2, deliver 5 encrypt packets -> cnt_enc = 3; assert rstn low mid-stream -> all outputs 0 immediately.
